alu_exec: RTL and testbench

Execute stage of the Hack CPU datapath, sitting directly downstream of the source-select stage. It consumes the valid/ready beat carrying x, y and the six Hack ALU control bits. It computes the Hack ALU function and presents the registered result plus zr/ng flags on a valid/ready interface toward write-back. A two-entry elastic buffer keeps full throughput under backpressure while the upstream ready stays a pure register decode.

---
 rtl/alu_exec.sv | 138 +++++++++++++
 tb/tb_alu_exec.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec -- Hack CPU execute stage.
//
// Takes one beat per accept, holding x/y and the six Hack ALU control bits.
// It computes the Hack ALU function and hands {out, zr, ng} downstream
// through a two-entry elastic buffer. rdy_s decodes only from the state
// register, so no combinational path runs from rdy_r to rdy_s.
//
// Ports
//   clk              clock, all state on the rising edge
//   rstn             asynchronous active-low reset
//   vld_s / rdy_s    upstream handshake (rdy_s is a register decode)
//   x_s, y_s         ALU operands, D_W bits
//   zx_s..no_s       Hack ALU control bits
//   vld_r / rdy_r    downstream handshake
//   out_r            ALU result, held stable while stalled
//   zr_r, ng_r       result flags: zero and negative
module alu_exec #(
  parameter int D_W = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           vld_s,
  output logic           rdy_s,
  input  logic [D_W-1:0] x_s,
  input  logic [D_W-1:0] y_s,
  input  logic           zx_s,
  input  logic           nx_s,
  input  logic           zy_s,
  input  logic           ny_s,
  input  logic           f_s,
  input  logic           no_s,
  output logic           vld_r,
  input  logic           rdy_r,
  output logic [D_W-1:0] out_r,
  output logic           zr_r,
  output logic           ng_r
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Hack ALU: pre-conditions each operand, then adds or ANDs them, then
  // optionally inverts the result. The adder wraps, so the carry out is lost.
  function automatic logic [D_W-1:0] hack_alu(
    input logic [D_W-1:0] x,
    input logic [D_W-1:0] y,
    input logic zx, input logic nx,
    input logic zy, input logic ny,
    input logic f,  input logic no
  );
    logic [D_W-1:0] x1, x2, y1, y2, o;
    x1 = zx ? '0 : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : y;
    y2 = ny ? ~y1 : y1;
    o  = f ? (x2 + y2) : (x2 & y2);
    return no ? ~o : o;
  endfunction

  state_t state;
  logic   acc_p0;

  logic [D_W-1:0] out_p0;
  logic           zr_p0;
  logic           ng_p0;

  logic [D_W-1:0] main_out_p1;
  logic           main_zr_p1;
  logic           main_ng_p1;
  logic [D_W-1:0] skid_out_p1;
  logic           skid_zr_p1;
  logic           skid_ng_p1;

  // Stage p0: combinational ALU on the incoming beat
  assign out_p0 = hack_alu(x_s, y_s, zx_s, nx_s, zy_s, ny_s, f_s, no_s);
  assign zr_p0  = (out_p0 == '0);
  assign ng_p0  = out_p0[D_W-1];

  assign rdy_s  = (state != TWO);
  assign acc_p0 = vld_s && rdy_s;

  // Stage p1: main and skid entries of the elastic buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= EMPTY;
      main_out_p1 <= '0;
      main_zr_p1  <= 1'b0;
      main_ng_p1  <= 1'b0;
      skid_out_p1 <= '0;
      skid_zr_p1  <= 1'b0;
      skid_ng_p1  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc_p0) begin
            main_out_p1 <= out_p0;
            main_zr_p1  <= zr_p0;
            main_ng_p1  <= ng_p0;
            state       <= ONE;
          end
        end
        ONE: begin
          if (acc_p0 && rdy_r) begin
            // Old beat leaves while the new one takes its place.
            main_out_p1 <= out_p0;
            main_zr_p1  <= zr_p0;
            main_ng_p1  <= ng_p0;
          end else if (acc_p0) begin
            skid_out_p1 <= out_p0;
            skid_zr_p1  <= zr_p0;
            skid_ng_p1  <= ng_p0;
            state       <= TWO;
          end else if (rdy_r) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (rdy_r) begin
            main_out_p1 <= skid_out_p1;
            main_zr_p1  <= skid_zr_p1;
            main_ng_p1  <= skid_ng_p1;
            state       <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign vld_r = (state != EMPTY);
  assign out_r = main_out_p1;
  assign zr_r  = main_zr_p1;
  assign ng_r  = main_ng_p1;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  localparam int D_W = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           vld_s;
  logic           rdy_s;
  logic [D_W-1:0] x_s, y_s;
  logic           zx_s, nx_s, zy_s, ny_s, f_s, no_s;
  logic           vld_r;
  logic           rdy_r;
  logic [D_W-1:0] out_r;
  logic           zr_r, ng_r;

  int ncmp  = 0;
  int nfail = 0;

  alu_exec #(.D_W(D_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .vld_s (vld_s),
    .rdy_s (rdy_s),
    .x_s   (x_s),
    .y_s   (y_s),
    .zx_s  (zx_s),
    .nx_s  (nx_s),
    .zy_s  (zy_s),
    .ny_s  (ny_s),
    .f_s   (f_s),
    .no_s  (no_s),
    .vld_r (vld_r),
    .rdy_r (rdy_r),
    .out_r (out_r),
    .zr_r  (zr_r),
    .ng_r  (ng_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream must not change a beat that is offered but not yet taken.
  logic           hold_q = 1'b0;
  logic [D_W+D_W+5:0] beat_q;
  always @(posedge clk) begin
    if (rstn === 1'b1 && hold_q)
      chk("upstream_stable", {16'd0, (beat_q == {x_s, y_s, zx_s, nx_s, zy_s, ny_s, f_s, no_s})}, 32'd1);
    hold_q = (rstn === 1'b1) && vld_s && !rdy_s;
    beat_q = {x_s, y_s, zx_s, nx_s, zy_s, ny_s, f_s, no_s};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [D_W-1:0] x, input logic [D_W-1:0] y, input logic [5:0] c);
    x_s = x;
    y_s = y;
    {zx_s, nx_s, zy_s, ny_s, f_s, no_s} = c;
    vld_s = 1'b1;
  endtask

  // Offer one beat, let it be accepted, check the registered result.
  task automatic put_chk(input string tag, input logic [D_W-1:0] x, input logic [D_W-1:0] y,
                         input logic [5:0] c, input logic [D_W-1:0] e_out,
                         input logic e_zr, input logic e_ng);
    drive(x, y, c);
    step();
    vld_s = 1'b0;
    chk({tag, "_vld"}, {31'd0, vld_r}, 32'd1);
    chk({tag, "_out"}, {16'd0, out_r}, {16'd0, e_out});
    chk({tag, "_zr"},  {31'd0, zr_r}, {31'd0, e_zr});
    chk({tag, "_ng"},  {31'd0, ng_r}, {31'd0, e_ng});
  endtask

  initial begin
    // Reset with random inputs
    rstn  = 1'b0;
    vld_s = 1'($urandom);
    x_s   = 16'($urandom);
    y_s   = 16'($urandom);
    {zx_s, nx_s, zy_s, ny_s, f_s, no_s} = 6'($urandom);
    rdy_r = 1'($urandom);
    #1;
    chk("rst_vld", {31'd0, vld_r}, 32'd0);
    chk("rst_rdy_s", {31'd0, rdy_s}, 32'd1);
    repeat (2) step();
    chk("rst_vld2", {31'd0, vld_r}, 32'd0);
    chk("rst_out", {16'd0, out_r}, 32'h0000);
    chk("rst_zr", {31'd0, zr_r}, 32'd0);
    chk("rst_ng", {31'd0, ng_r}, 32'd0);
    vld_s = 1'b0;
    rdy_r = 1'b1;
    rstn  = 1'b1;
    step();
    chk("idle_vld", {31'd0, vld_r}, 32'd0);
    chk("idle_rdy_s", {31'd0, rdy_s}, 32'd1);

    // Function vectors, back-to-back at full rate
    put_chk("add",     16'd5,     16'd7,     6'b000010, 16'h000C, 1'b0, 1'b0);
    put_chk("zero",    16'h1234,  16'h5678,  6'b101010, 16'h0000, 1'b1, 1'b0);
    put_chk("minus1",  16'h1234,  16'h5678,  6'b111010, 16'hFFFF, 1'b0, 1'b1);
    put_chk("one",     16'h1234,  16'h5678,  6'b111111, 16'h0001, 1'b0, 1'b0);
    put_chk("sub",     16'd3,     16'd5,     6'b010011, 16'hFFFE, 1'b0, 1'b1);
    put_chk("wrap",    16'h7FFF,  16'h0001,  6'b000010, 16'h8000, 1'b0, 1'b1);
    put_chk("and",     16'hF0F0,  16'hFF00,  6'b000000, 16'hF000, 1'b0, 1'b1);
    put_chk("carry",   16'hFFFF,  16'h0002,  6'b000010, 16'h0001, 1'b0, 1'b0);
    step();
    chk("drain_vld", {31'd0, vld_r}, 32'd0);

    // Backpressure: beats 1,2,3 with rdy_r low
    rdy_r = 1'b0;
    drive(16'd1, 16'd0, 6'b000010);
    step();
    chk("bp1_out", {16'd0, out_r}, 32'd1);
    chk("bp1_rdy_s", {31'd0, rdy_s}, 32'd1);
    drive(16'd2, 16'd0, 6'b000010);
    step();
    chk("bp2_out", {16'd0, out_r}, 32'd1);
    chk("bp2_rdy_s", {31'd0, rdy_s}, 32'd0);
    drive(16'd3, 16'd0, 6'b000010);
    step();
    chk("bp3_out_stall", {16'd0, out_r}, 32'd1);
    chk("bp3_vld", {31'd0, vld_r}, 32'd1);
    chk("bp3_rdy_s", {31'd0, rdy_s}, 32'd0);
    rdy_r = 1'b1;
    step();
    chk("bp_o1_out", {16'd0, out_r}, 32'd2);
    chk("bp_o1_rdy_s", {31'd0, rdy_s}, 32'd1);
    step();
    vld_s = 1'b0;
    chk("bp_o2_out", {16'd0, out_r}, 32'd3);
    chk("bp_o2_vld", {31'd0, vld_r}, 32'd1);
    step();
    chk("bp_end_vld", {31'd0, vld_r}, 32'd0);

    // Reset while TWO is full
    rdy_r = 1'b0;
    drive(16'h0011, 16'd0, 6'b000010);
    step();
    drive(16'h0022, 16'd0, 6'b000010);
    step();
    vld_s = 1'b0;
    chk("two_rdy_s", {31'd0, rdy_s}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", {31'd0, vld_r}, 32'd0);
    chk("arst_out", {16'd0, out_r}, 32'h0000);
    chk("arst_rdy_s", {31'd0, rdy_s}, 32'd1);
    #2 rstn = 1'b1;
    rdy_r = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_idle", {31'd0, vld_r}, 32'd0);
    end
    put_chk("post_rst", 16'h0040, 16'h0002, 6'b000010, 16'h0042, 1'b0, 1'b0);
    step();
    chk("post_rst_drain", {31'd0, vld_r}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
